// File: rtl/pacman_death_controller.sv
// Pacman life/death sequencer: freezes play, counts lives, times the death animation.
// Optional PACMAN_RESPAWN_GRACE_EN extends invulnerability to GRACE_FRAMES after each (re)spawn.
module pacman_death_controller #(
  parameter int INIT_LIVES   = 3,
  parameter int LIVES_W      = 3,
  parameter int DEATH_FRAMES = 120,
  parameter int GRACE_FRAMES = 90,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_game,
  input  logic               pacman_is_dead,
  output logic               freeze,
  output logic               respawn_pulse,
  output logic [LIVES_W-1:0] lives_left,
  output logic               game_over,
  output logic [1:0]         state,
  output logic               invulnerable
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    DYING = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
  localparam logic [CNT_W-1:0]   DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             arm_now;

  assign state = st;

`ifdef PACMAN_RESPAWN_GRACE_EN
  localparam logic [CNT_W-1:0] GRACE_LAST = CNT_W'(GRACE_FRAMES - 1);

  always_comb begin
    arm_now = frame_tick && (cnt == GRACE_LAST);
  end
`else
  logic unused_grace;

  assign unused_grace = |CNT_W'(GRACE_FRAMES);

  always_comb begin
    arm_now = frame_tick;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= IDLE;
      lives_left    <= LIVES_INIT;
      freeze        <= 1'b1;
      respawn_pulse <= 1'b0;
      game_over     <= 1'b0;
      invulnerable  <= 1'b0;
      cnt           <= '0;
      armed         <= 1'b0;
    end else begin
      respawn_pulse <= 1'b0;
      unique case (st)
        IDLE, OVER: begin
          if (start_game) begin
            st            <= PLAY;
            lives_left    <= LIVES_INIT;
            respawn_pulse <= 1'b1;
            freeze        <= 1'b0;
            game_over     <= 1'b0;
            invulnerable  <= 1'b1;
            cnt           <= '0;
            armed         <= 1'b0;
          end
        end
        PLAY: begin
          // Collisions stay masked until the reload has settled.
          if (!armed) begin
            if (frame_tick) begin
              cnt <= cnt + 1'b1;
            end
            if (arm_now) begin
              armed        <= 1'b1;
              invulnerable <= 1'b0;
            end
          end else if (pacman_is_dead) begin
            st         <= DYING;
            lives_left <= (lives_left != '0) ? lives_left - 1'b1 : '0;
            freeze     <= 1'b1;
            cnt        <= '0;
          end
        end
        DYING: begin
          if (frame_tick) begin
            if (cnt == DEATH_LAST) begin
              if (lives_left == '0) begin
                st        <= OVER;
                game_over <= 1'b1;
              end else begin
                st            <= PLAY;
                respawn_pulse <= 1'b1;
                freeze        <= 1'b0;
                invulnerable  <= 1'b1;
                armed         <= 1'b0;
                cnt           <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_death_controller.sv
// Randomized bench for pacman_death_controller against a behavioural game model.
// Directed phases: start, death/respawn, game over, held collision, mid-death reset.
module tb_pacman_death_controller;

  localparam int INIT  = 3;
  localparam int DEATH = 120;
  localparam int GRACE = 90;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start_game;
  logic       pacman_is_dead;
  logic       freeze;
  logic       respawn_pulse;
  logic [2:0] lives_left;
  logic       game_over;
  logic [1:0] state;
  logic       invulnerable;

  pacman_death_controller #(
    .INIT_LIVES(INIT),
    .LIVES_W(3),
    .DEATH_FRAMES(DEATH),
    .GRACE_FRAMES(GRACE),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .start_game(start_game),
    .pacman_is_dead(pacman_is_dead),
    .freeze(freeze),
    .respawn_pulse(respawn_pulse),
    .lives_left(lives_left),
    .game_over(game_over),
    .state(state),
    .invulnerable(invulnerable)
  );

  always #5 clk = ~clk;

  // Model of the game: mode, lives, frames watched, and whether hits count.
  localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_OVER = 3;
  int m_mode, m_lives, m_frames, m_tps;
  bit m_hits_count, m_pulse;

  int total = 0;
  int passed = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_lives = INIT;
    m_frames = 0;
    m_tps = 0;
    m_hits_count = 0;
    m_pulse = 0;
  endtask

  task automatic model_step(input bit s, input bit t, input bit d);
    m_pulse = 0;
    if (m_mode == M_IDLE || m_mode == M_OVER) begin
      if (s) begin
        m_mode = M_PLAY;
        m_lives = INIT;
        m_pulse = 1;
        m_hits_count = 0;
        m_tps = 0;
      end
    end else if (m_mode == M_PLAY) begin
      if (!m_hits_count) begin
        if (t) m_tps++;
`ifdef PACMAN_RESPAWN_GRACE_EN
        if (m_tps >= GRACE) m_hits_count = 1;
`else
        if (m_tps >= 1) m_hits_count = 1;
`endif
      end else if (d) begin
        m_mode = M_DYING;
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        m_frames = 0;
      end
    end else begin
      if (t) m_frames++;
      if (m_frames == DEATH) begin
        if (m_lives == 0) m_mode = M_OVER;
        else begin
          m_mode = M_PLAY;
          m_pulse = 1;
          m_hits_count = 0;
          m_tps = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    check("state", 8'(state), 8'(m_mode));
    check("lives", 8'(lives_left), 8'(m_lives));
    check("freeze", 8'(freeze), 8'(m_mode != M_PLAY));
    check("respawn", 8'(respawn_pulse), 8'(m_pulse));
    check("game_over", 8'(game_over), 8'(m_mode == M_OVER));
    check("invuln", 8'(invulnerable),
          8'(m_mode == M_PLAY && !m_hits_count));
  endtask

  task automatic cycle(input bit s, input bit t, input bit d);
    start_game = s;
    frame_tick = t;
    pacman_is_dead = d;
    @(posedge clk);
    #1;
    model_step(s, t, d);
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0;
    start_game = 1'b0;
    pacman_is_dead = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    cycle(0, 1, 1);
    cycle(1, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 1, 1);
    cycle(0, 0, 1);
    repeat (DEATH + 5) cycle(0, 1, 0);

    for (int i = 0; i < 3000 && m_mode != M_OVER; i++)
      cycle(0, 1, m_mode == M_PLAY);
    check("reach_over", 8'(state), 8'(2'b11));
    cycle(0, 1, 1);
    cycle(1, 0, 0);

    repeat (600) cycle(0, 1'($urandom % 2), 1);

    repeat (4000)
      cycle($urandom % 60 == 0, 1'($urandom % 2), $urandom % 25 == 0);

    for (int i = 0; i < 3000; i++) begin
      if (m_mode == M_DYING && m_frames == 60) break;
      cycle(m_mode == M_IDLE || m_mode == M_OVER, 1, 1);
    end
    check("reach_dying60", 8'(state), 8'(2'b10));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 1, 1);
    cycle(1, 1, 1);
    cycle(0, 1, 1);
    cycle(0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
